lru_ctrl: RTL and testbench

- Sequencer for the 64-entry x 8-bit LRU state table of the 4-way set-associative cache. The table is external, single-port, read-first, with 1-cycle read latency.
- Serialises touch requests (hit way becomes MRU) and victim requests (return the LRU way, then promote it to MRU) from the cache FSM as read-modify-write cycles.
- After reset, sweeps the table to a legal initial ordering.

---
 rtl/lru_pkg.sv | 27 ++
 rtl/lru_rank_update.sv | 48 ++++
 rtl/lru_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lru_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lru_pkg.sv
// Shared constants and helpers for the LRU state-table sequencer.
package lru_pkg;

   localparam int unsigned RANK_W       = 2;
   localparam int unsigned WAYS         = 4;
   localparam logic [7:0]  INIT_VAL_DEF = 8'hE4;

   localparam logic OP_TOUCH  = 1'b0;
   localparam logic OP_VICTIM = 1'b1;

   // FSM state encoding
   localparam logic [1:0] StInit = 2'd0;
   localparam logic [1:0] StIdle = 2'd1;
   localparam logic [1:0] StRd   = 2'd2;
   localparam logic [1:0] StWb   = 2'd3;

   // An entry is legal when the four ranks form a permutation of {0,1,2,3}.
   function automatic logic is_legal(input logic [7:0] e);
      logic [3:0] seen;
      seen = '0;
      for (int w = 0; w < WAYS; w++) begin
         seen[e[2*w +: RANK_W]] = 1'b1;
      end
      return &seen;
   endfunction

endpackage

// File: rtl/lru_rank_update.sv
// Combinational rank update for one LRU entry: picks the target way and promotes it to MRU.
module lru_rank_update
   import lru_pkg::*;
#(
   parameter logic [7:0] INIT_VAL    = INIT_VAL_DEF,
   parameter bit         FIX_ILLEGAL = 1'b0
) (
   input  logic [7:0] entry_i,
   input  logic       op_i,
   input  logic [1:0] way_i,
   output logic [7:0] entry_o,
   output logic [1:0] way_o,
   output logic       legal_o
);

   logic [7:0] e;
   logic [1:0] old_r;
   logic [1:0] r;

   // Select target, then bump every way that was more recent than it.
   always_comb begin
      legal_o = is_legal(entry_i);
      e       = (FIX_ILLEGAL && !legal_o) ? INIT_VAL : entry_i;
      way_o   = 2'd0;
      if (op_i == OP_TOUCH) begin
         way_o = way_i;
      end else begin
         // Descending scan so the lowest-index rank-3 way wins.
         for (int w = WAYS - 1; w >= 0; w--) begin
            if (e[2*w +: RANK_W] == 2'd3) way_o = 2'(w);
         end
      end
      old_r   = e[{way_o, 1'b0} +: RANK_W];
      entry_o = '0;
      r       = '0;
      for (int w = 0; w < WAYS; w++) begin
         r = e[2*w +: RANK_W];
         if (2'(w) == way_o) begin
            entry_o[2*w +: RANK_W] = '0;
         end else if (r < old_r) begin
            entry_o[2*w +: RANK_W] = r + 2'd1;
         end else begin
            entry_o[2*w +: RANK_W] = r;
         end
      end
   end

endmodule

// File: rtl/lru_ctrl.sv
// Read-modify-write sequencer for the external LRU state table.
// Optional macro LRU_CTRL_CHECK_EN adds a sticky err output and repairs illegal entries.
module lru_ctrl
   import lru_pkg::*;
#(
   parameter int unsigned SET_W    = 6,
   parameter logic [7:0]  INIT_VAL = INIT_VAL_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_op,
   input  logic [SET_W-1:0] req_set,
   input  logic [1:0]       req_way,
   output logic             rsp_valid,
   output logic [1:0]       rsp_way,
   output logic             init_done,
   output logic             tbl_ena,
   output logic             tbl_wea,
   output logic [SET_W-1:0] tbl_addr,
   output logic [7:0]       tbl_din,
   input  logic [7:0]       tbl_dout
`ifdef LRU_CTRL_CHECK_EN
   ,
   output logic             err
`endif
);

   logic [1:0]       state_q, state_d;
   logic [SET_W:0]   cnt_q, cnt_d;
   logic             op_q, op_d;
   logic [SET_W-1:0] set_q, set_d;
   logic [1:0]       way_q, way_d;
   logic             ready_q, ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             done_q, done_d;
   logic             ena_q, ena_d;
   logic             wea_q, wea_d;
   logic [SET_W-1:0] addr_q, addr_d;
   logic [7:0]       din_q, din_d;

   logic [7:0] upd_entry;
   logic [1:0] upd_way;
   logic       legal;

`ifdef LRU_CTRL_CHECK_EN
   localparam bit FixIllegal = 1'b1;
`else
   localparam bit FixIllegal = 1'b0;
`endif

   lru_rank_update #(
      .INIT_VAL    (INIT_VAL),
      .FIX_ILLEGAL (FixIllegal)
   ) u_rank_update (
      .entry_i (tbl_dout),
      .op_i    (op_q),
      .way_i   (way_q),
      .entry_o (upd_entry),
      .way_o   (upd_way),
      .legal_o (legal)
   );

   // Next-state and next-output decode; registered outputs describe the coming cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      set_d       = set_q;
      way_d       = way_q;
      ready_d     = 1'b0;
      rsp_valid_d = 1'b0;
      done_d      = done_q;
      ena_d       = 1'b0;
      wea_d       = 1'b0;
      addr_d      = '0;
      din_d       = '0;
      case (state_q)
         StInit: begin
            // Top counter bit set means every address has been written.
            if (cnt_q[SET_W]) begin
               state_d = StIdle;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end else begin
               ena_d  = 1'b1;
               wea_d  = 1'b1;
               addr_d = cnt_q[SET_W-1:0];
               din_d  = INIT_VAL;
               cnt_d  = cnt_q + 1'b1;
            end
         end
         StIdle: begin
            if (req_valid && ready_q) begin
               op_d    = req_op;
               set_d   = req_set;
               way_d   = req_way;
               state_d = StRd;
               ena_d   = 1'b1;
               addr_d  = req_set;
            end else begin
               ready_d = 1'b1;
            end
         end
         StRd: begin
            state_d     = StWb;
            ena_d       = 1'b1;
            wea_d       = 1'b1;
            addr_d      = set_q;
            rsp_valid_d = 1'b1;
         end
         StWb: begin
            state_d = StIdle;
            ready_d = 1'b1;
         end
         default: state_d = StInit;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= StInit;
         cnt_q       <= '0;
         op_q        <= OP_TOUCH;
         set_q       <= '0;
         way_q       <= '0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         done_q      <= 1'b0;
         ena_q       <= 1'b0;
         wea_q       <= 1'b0;
         addr_q      <= '0;
         din_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         set_q       <= set_d;
         way_q       <= way_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         done_q      <= done_d;
         ena_q       <= ena_d;
         wea_q       <= wea_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
      end
   end

`ifdef LRU_CTRL_CHECK_EN
   logic err_q, err_d;

   // Sticky flag: any illegal entry seen during write-back.
   always_comb begin
      err_d = err_q | ((state_q == StWb) && !legal);
   end

   // Error flag register.
   always_ff @(posedge clk) begin
      if (!rstn) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err = err_q;
`else
   // Legality only feeds the error flag, which is absent in this build.
   logic unused_legal;
   assign unused_legal = legal;
`endif

   // Write data and response way depend on the read data, which only arrives in WB.
   assign tbl_din   = (state_q == StWb) ? upd_entry : din_q;
   assign rsp_way   = (state_q == StWb) ? upd_way : 2'd0;
   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign init_done = done_q;
   assign tbl_ena   = ena_q;
   assign tbl_wea   = wea_q;
   assign tbl_addr  = addr_q;

endmodule

// File: tb/tb_lru_ctrl.sv
// Directed bench for lru_ctrl with a behavioural single-port read-first table.
module tb_lru_ctrl;

   localparam int SET_W = 6;

   logic             clk = 1'b0;
   logic             rstn;
   logic             req_valid;
   logic             req_ready;
   logic             req_op;
   logic [SET_W-1:0] req_set;
   logic [1:0]       req_way;
   logic             rsp_valid;
   logic [1:0]       rsp_way;
   logic             init_done;
   logic             tbl_ena;
   logic             tbl_wea;
   logic [SET_W-1:0] tbl_addr;
   logic [7:0]       tbl_din;
   logic [7:0]       tbl_dout;
`ifdef LRU_CTRL_CHECK_EN
   logic             err;
`endif

   logic [7:0]       mem [64];
   logic             poke_en = 1'b0;
   logic [SET_W-1:0] poke_addr = '0;
   logic [7:0]       poke_data = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lru_ctrl #(
      .SET_W    (SET_W),
      .INIT_VAL (8'hE4)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_set   (req_set),
      .req_way   (req_way),
      .rsp_valid (rsp_valid),
      .rsp_way   (rsp_way),
      .init_done (init_done),
      .tbl_ena   (tbl_ena),
      .tbl_wea   (tbl_wea),
      .tbl_addr  (tbl_addr),
      .tbl_din   (tbl_din),
`ifdef LRU_CTRL_CHECK_EN
      .err       (err),
`endif
      .tbl_dout  (tbl_dout)
   );

   // Table model: read-first, one-cycle read latency; bench pokes preload entries.
   always @(posedge clk) begin
      if (poke_en) begin
         mem[poke_addr] <= poke_data;
      end else if (tbl_ena) begin
         tbl_dout <= mem[tbl_addr];
         if (tbl_wea) mem[tbl_addr] <= tbl_din;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [SET_W-1:0] a, input logic [7:0] d);
      poke_addr = a;
      poke_data = d;
      poke_en   = 1'b1;
      tick();
      poke_en   = 1'b0;
   endtask

   // Runs the init sweep with a request held pending; call right after releasing reset.
   task automatic run_init(input string tag);
      int nwr = 0, wr_bad = 0, rdy_bad = 0, first_wr = -1, done_c = -1, mem_bad = 0;
      req_valid = 1'b1;
      req_op    = 1'b1;
      req_set   = 6'd3;
      for (int c = 0; c < 200 && !init_done; c++) begin
         tick();
         if (tbl_ena && tbl_wea) begin
            if (tbl_addr !== nwr[5:0] || tbl_din !== 8'hE4) wr_bad++;
            if (first_wr < 0) first_wr = c;
            nwr++;
         end
         if (tbl_ena && !tbl_wea) wr_bad++;
         if (req_ready && !init_done) rdy_bad++;
         if (init_done) done_c = c;
      end
      req_valid = 1'b0;
      for (int i = 0; i < 64; i++) if (mem[i] !== 8'hE4) mem_bad++;
      chk({tag, "_done"}, init_done, 1'b1);
      chk({tag, "_nwr"}, nwr, 64);
      chk({tag, "_span"}, done_c - first_wr, 64);
      chk({tag, "_wr_bad"}, wr_bad, 0);
      chk({tag, "_rdy_bad"}, rdy_bad, 0);
      chk({tag, "_mem"}, mem_bad, 0);
      chk({tag, "_ready"}, req_ready, 1'b1);
   endtask

   // One request from IDLE, checking RD, WB and the return to IDLE.
   task automatic do_req(input string tag, input logic op, input logic [SET_W-1:0] s,
                         input logic [1:0] w, input logic [1:0] exp_way,
                         input logic [7:0] exp_din);
      chk({tag, "_ready"}, req_ready, 1'b1);
      req_valid = 1'b1;
      req_op    = op;
      req_set   = s;
      req_way   = w;
      tick();
      req_valid = 1'b0;
      chk({tag, "_rd"}, {tbl_ena, tbl_wea, tbl_addr, rsp_valid, req_ready},
          {1'b1, 1'b0, s, 1'b0, 1'b0});
      tick();
      chk({tag, "_wb"}, {tbl_ena, tbl_wea, tbl_addr, tbl_din, rsp_valid, rsp_way},
          {1'b1, 1'b1, s, exp_din, 1'b1, exp_way});
      tick();
      chk({tag, "_post"}, {rsp_valid, req_ready, tbl_ena}, {1'b0, 1'b1, 1'b0});
      chk({tag, "_mem"}, mem[s], exp_din);
   endtask

   initial begin
      int acc = 0, rsp = 0, last = -1, gap_bad = 0;
      rstn      = 1'b0;
      req_valid = 1'b0;
      req_op    = 1'b0;
      req_set   = '0;
      req_way   = '0;
      tick();
      tick();
      tick();
      chk("reset_outs", {req_ready, rsp_valid, rsp_way, init_done, tbl_ena, tbl_wea,
                         tbl_addr, tbl_din}, 32'h0);
      rstn = 1'b1;
      run_init("init");

      // Victim on the reset ordering, then again on the updated entry.
      do_req("vic1", 1'b1, 6'd5, 2'd0, 2'd3, 8'h39);
      do_req("vic2", 1'b1, 6'd5, 2'd1, 2'd2, 8'h4E);

      poke(6'd5, 8'hE4);
      do_req("touch", 1'b0, 6'd5, 2'd2, 2'd2, 8'hC9);

      // Back-to-back with req_valid held: touches way 1 of set 7 repeatedly.
      req_valid = 1'b1;
      req_op    = 1'b0;
      req_set   = 6'd7;
      req_way   = 2'd1;
      for (int c = 0; c < 12; c++) begin
         if (req_valid && req_ready) begin
            if (last >= 0 && c - last != 3) gap_bad++;
            last = c;
            acc++;
         end
         if (rsp_valid) rsp++;
         tick();
      end
      req_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (rsp_valid) rsp++;
         tick();
      end
      chk("b2b_accepts", acc, 4);
      chk("b2b_rsps", rsp, 4);
      chk("b2b_gap", gap_bad, 0);
      chk("b2b_mem", mem[7], 8'hE1);
      chk("b2b_ready", req_ready, 1'b1);

      // Corrupt entry on a victim.
      poke(6'd10, 8'h00);
`ifdef LRU_CTRL_CHECK_EN
      chk("err_pre", err, 1'b0);
      do_req("corrupt", 1'b1, 6'd10, 2'd0, 2'd3, 8'h39);
      chk("err_set", err, 1'b1);
      do_req("after_err", 1'b0, 6'd11, 2'd3, 2'd3, 8'h39);
      chk("err_sticky", err, 1'b1);
`else
      do_req("corrupt", 1'b1, 6'd10, 2'd0, 2'd0, 8'h00);
`endif

      // Reset while the read is outstanding: nothing may be written back.
      req_valid = 1'b1;
      req_op    = 1'b1;
      req_set   = 6'd9;
      tick();
      req_valid = 1'b0;
      chk("rst_rd_phase", {tbl_ena, tbl_wea, tbl_addr}, {1'b1, 1'b0, 6'd9});
      rstn = 1'b0;
      tick();
      chk("rst_outs", {req_ready, rsp_valid, rsp_way, init_done, tbl_ena, tbl_wea,
                       tbl_addr, tbl_din}, 32'h0);
`ifdef LRU_CTRL_CHECK_EN
      chk("rst_err", err, 1'b0);
`endif
      tick();
      chk("rst_no_rsp", rsp_valid, 1'b0);
      chk("rst_no_wb", mem[9], 8'hE4);
      rstn = 1'b1;
      run_init("reinit");

      // Touching the MRU way rewrites the same entry.
      do_req("touch_mru", 1'b0, 6'd9, 2'd0, 2'd0, 8'hE4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
